// File: rtl/sfq_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sfq_tx_pkg
// Description : Shared definitions for the SFQ DFFT pulse transmitter:
//               transmitter state encoding, default guard-window lengths,
//               guard counter width and a helper that turns a guard length
//               into the counter load value.
// Revision    : 1.0 - initial release
// ============================================================================
package sfq_tx_pkg;

    // Guard counter width; covers guard windows of 0..15 cycles.
    localparam int unsigned c_guard_w = 4;

    // Default idle cycles between a set toggle and the following clkp toggle.
    localparam int unsigned c_setup_cyc_def = 2;

    // Default idle cycles after a clkp toggle before the next set toggle.
    localparam int unsigned c_hold_cyc_def = 2;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_SET        = 3'd1,
        ST_SETUP_WAIT = 3'd2,
        ST_CLK        = 3'd3,
        ST_HOLD_WAIT  = 3'd4
    } tx_state_e;

    // A window of N cycles is timed by loading N-1 and waiting for zero.
    // A zero-length window is never loaded (the FSM skips the wait state).
    function automatic logic [c_guard_w-1:0] guard_load(input int unsigned cyc);
        if (cyc == 0) begin
            return '0;
        end
        return c_guard_w'(cyc - 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sfq_guard_timer.sv
`default_nettype none
// ============================================================================
// Module      : sfq_guard_timer
// Description : Down-counting guard timer shared by the setup and hold
//               windows. Loads a start value, counts down while enabled and
//               sticks at zero (no wrap).
// Ports       : clk      - system clock
//               rst_n    - asynchronous active-low reset
//               load     - load load_val into the counter this cycle
//               load_val - start value (window length minus one)
//               count    - decrement enable
//               expired  - counter is at zero
// Revision    : 1.0 - initial release
// ============================================================================
module sfq_guard_timer
    import sfq_tx_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [c_guard_w-1:0] load_val,
    input  logic                 count,
    output logic                 expired
);

    logic [c_guard_w-1:0] cnt_q;
    logic [c_guard_w-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (count && (cnt_q != '0)) begin
            cnt_d = cnt_q - c_guard_w'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/dfft_pulse_tx.sv
`default_nettype none
// ============================================================================
// Module      : dfft_pulse_tx
// Description : Serialises a word MSB first onto toggle-encoded SFQ set and
//               clock lines for a DFFT, with programmable setup and hold
//               guard windows, and predicts the DFFT output level.
// Ports       : clk      - system clock (rising edge)
//               rst_n    - asynchronous active-low reset
//               in_valid - host offers in_data
//               in_ready - block accepts a word this cycle
//               in_data  - word to transmit, MSB first
//               set_o    - toggle-encoded set line
//               clkp_o   - toggle-encoded SFQ clock line
//               exp_out  - predicted DFFT output level
//               busy     - a word is in flight
//               done     - one-cycle pulse after the last hold window
// Revision    : 1.0 - initial release
// ============================================================================
module dfft_pulse_tx
    import sfq_tx_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned SETUP_CYC = c_setup_cyc_def,
    parameter int unsigned HOLD_CYC  = c_hold_cyc_def
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              set_o,
    output logic              clkp_o,
    output logic              exp_out,
    output logic              busy,
    output logic              done
);

    localparam int unsigned          c_idx_w      = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [c_idx_w-1:0]   c_idx_top    = c_idx_w'(DATA_W - 1);
    localparam logic [c_guard_w-1:0] c_setup_ld   = guard_load(SETUP_CYC);
    localparam logic [c_guard_w-1:0] c_hold_ld    = guard_load(HOLD_CYC);
    localparam bit                   c_skip_setup = (SETUP_CYC == 0);
    localparam bit                   c_skip_hold  = (HOLD_CYC == 0);

    tx_state_e            state_q;
    tx_state_e            state_d;
    logic [DATA_W-1:0]    shift_q;
    logic [DATA_W-1:0]    shift_d;
    logic [c_idx_w-1:0]   idx_q;
    logic [c_idx_w-1:0]   idx_d;
    logic                 set_q;
    logic                 set_d;
    logic                 clkp_q;
    logic                 clkp_d;
    logic                 exp_q;
    logic                 exp_d;
    logic                 done_q;
    logic                 done_d;
    logic                 live_q;
    logic                 live_d;

    logic                 tmr_load;
    logic [c_guard_w-1:0] tmr_load_val;
    logic                 tmr_count;
    logic                 tmr_expired;

    logic                 accept;
    logic                 cur_bit;
    logic                 last_bit;
    logic                 bit_end;

    sfq_guard_timer u_guard (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .count    (tmr_count),
        .expired  (tmr_expired)
    );

    // live_q keeps in_ready low until the first edge after reset release.
    assign live_d   = 1'b1;
    // Holding off in_ready during the done cycle keeps done and a new
    // acceptance from landing in the same cycle.
    assign in_ready = live_q && (state_q == ST_IDLE) && !done_q;
    assign accept   = in_valid && in_ready;
    assign cur_bit  = shift_q[DATA_W-1];
    assign last_bit = (idx_q == '0);
    // A bit finishes either in CLK (no hold window) or when the hold window expires.
    assign bit_end  = ((state_q == ST_CLK) && c_skip_hold) ||
                      ((state_q == ST_HOLD_WAIT) && tmr_expired);

    // ---------------------------------------------------------------- state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_SET;
                end
            end
            ST_SET: begin
                state_d = c_skip_setup ? ST_CLK : ST_SETUP_WAIT;
            end
            ST_SETUP_WAIT: begin
                if (tmr_expired) begin
                    state_d = ST_CLK;
                end
            end
            ST_CLK: begin
                if (!c_skip_hold) begin
                    state_d = ST_HOLD_WAIT;
                end else begin
                    state_d = last_bit ? ST_IDLE : ST_SET;
                end
            end
            ST_HOLD_WAIT: begin
                if (tmr_expired) begin
                    state_d = last_bit ? ST_IDLE : ST_SET;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------- outputs / datapath
    always_comb begin
        shift_d      = shift_q;
        idx_d        = idx_q;
        set_d        = set_q;
        clkp_d       = clkp_q;
        exp_d        = exp_q;
        done_d       = 1'b0;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        tmr_count    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    shift_d = in_data;
                    idx_d   = c_idx_top;
                end
            end
            ST_SET: begin
                if (cur_bit) begin
                    set_d = ~set_q;
                end
                if (!c_skip_setup) begin
                    tmr_load     = 1'b1;
                    tmr_load_val = c_setup_ld;
                end
            end
            ST_SETUP_WAIT: begin
                tmr_count = 1'b1;
            end
            ST_CLK: begin
                clkp_d = ~clkp_q;
                // The DFFT output flips whenever a clock pulse reads a stored 1.
                if (cur_bit) begin
                    exp_d = ~exp_q;
                end
                if (!c_skip_hold) begin
                    tmr_load     = 1'b1;
                    tmr_load_val = c_hold_ld;
                end
            end
            ST_HOLD_WAIT: begin
                tmr_count = 1'b1;
            end
            default: begin
            end
        endcase

        if (bit_end) begin
            if (last_bit) begin
                done_d = 1'b1;
            end else begin
                idx_d   = idx_q - c_idx_w'(1);
                shift_d = shift_q << 1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            idx_q   <= '0;
            set_q   <= 1'b0;
            clkp_q  <= 1'b0;
            exp_q   <= 1'b0;
            done_q  <= 1'b0;
            live_q  <= 1'b0;
        end else begin
            shift_q <= shift_d;
            idx_q   <= idx_d;
            set_q   <= set_d;
            clkp_q  <= clkp_d;
            exp_q   <= exp_d;
            done_q  <= done_d;
            live_q  <= live_d;
        end
    end

    assign set_o   = set_q;
    assign clkp_o  = clkp_q;
    assign exp_out = exp_q;
    assign busy    = (state_q != ST_IDLE);
    assign done    = done_q;

endmodule
`default_nettype wire

// File: doc/dfft_pulse_tx.md
DFFT_PULSE_TX -- requirements
Module: dfft_pulse_tx

Interface
REQ-001 Parameter DATA_W, default 8: width of one transmitted word.
REQ-002 Parameter SETUP_CYC, default 2: idle clk cycles between a set toggle and the following clkp toggle, range 0..15.
REQ-003 Parameter HOLD_CYC, default 2: idle clk cycles after a clkp toggle before the next set toggle, range 0..15.
REQ-004 Port clk, input, 1: single system clock; all state changes occur on its rising edge.
REQ-005 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-006 Port in_valid, input, 1: the host offers in_data.
REQ-007 Port in_ready, output, 1: the block accepts a word this cycle.
REQ-008 Port in_data, input, DATA_W: word to transmit, MSB first.
REQ-009 Port set_o, output, 1: toggle-encoded set line; each level transition is one SFQ set pulse.
REQ-010 Port clkp_o, output, 1: toggle-encoded SFQ clock line; each level transition is one clock pulse.
REQ-011 Port exp_out, output, 1: predicted DFFT out level; toggles when a clock pulse reads a stored 1.
REQ-012 Port busy, output, 1: a word is in flight.
REQ-013 Port done, output, 1: one-cycle pulse after the last bit's hold window ends.

Function
REQ-014 States SHALL be IDLE, SET, SETUP_WAIT, CLK, HOLD_WAIT.
REQ-015 in_ready SHALL be 1 only in IDLE, and busy SHALL equal (state != IDLE).
REQ-016 An in_valid and in_ready edge SHALL latch in_data into a shift register, set the bit index to DATA_W-1, and enter SET.
REQ-017 SET (1 cycle): if the current bit is 1, toggle set_o; otherwise leave set_o unchanged; then go to SETUP_WAIT, or to CLK when SETUP_CYC=0.
REQ-018 SETUP_WAIT SHALL last exactly SETUP_CYC cycles, then go to CLK.
REQ-019 CLK (1 cycle): toggle clkp_o unconditionally, toggle exp_out if and only if the current bit is 1, then go to HOLD_WAIT, or skip it when HOLD_CYC=0.
REQ-020 On HOLD_WAIT exit: if the bit index is 0, go to IDLE and pulse done for 1 cycle; otherwise decrement the index, shift, and go to SET.
REQ-021 Per-bit latency SHALL be 2+SETUP_CYC+HOLD_CYC cycles, with no gaps between bits.
REQ-022 At most one of set_o and clkp_o SHALL toggle in any cycle; set and clock pulses SHALL never coincide.
REQ-023 in_valid SHALL be ignored while busy, and in_data SHALL be sampled only at acceptance.
REQ-024 done and a new acceptance SHALL NOT occur in the same cycle; the earliest next acceptance is the cycle after done.
REQ-025 The guard counter SHALL be 4 bits wide, load SETUP_CYC-1 or HOLD_CYC-1, and count down to 0 without wrap.

Reset
REQ-026 While rst_n=0, all outputs SHALL be 0 (set_o, clkp_o, exp_out, busy, done, in_ready), the state SHALL be IDLE, and the counters and shift register SHALL be cleared.
REQ-027 in_ready SHALL go to 1 on the first clk rising edge after rst_n deasserts.
REQ-028 Reset during a word SHALL abort it immediately, with no done pulse and no further toggles.

Structure
REQ-029 The state enum, the default SETUP_CYC and HOLD_CYC values, and the guard counter width SHALL live in the shared package sfq_tx_pkg.
REQ-030 The guard wait SHALL be one sub-module, sfq_guard_timer (load, count, expired), instantiated once and shared by SETUP_WAIT and HOLD_WAIT.

Verification
REQ-031 Defaults, send 0xA5 -> set_o toggles 4 times, clkp_o toggles 8 times, exp_out ends at 0, done exactly 48 cycles after the accepting edge.
REQ-032 Defaults, send 0x00 -> set_o never toggles, clkp_o toggles 8 times, exp_out stays 0.
REQ-033 SETUP_CYC=0, HOLD_CYC=0, send 0xFF -> 16 alternating toggles, one per cycle (set_o, clkp_o, ...), exp_out ends at 0, done 16 cycles after acceptance.
REQ-034 Defaults, rst_n driven low at cycle 10 of a word -> all outputs 0 asynchronously, no done pulse, in_ready=1 one edge after release.
REQ-035 Defaults, in_valid held high across two words 0x80 then 0x01 -> second accepted the cycle after the first done, exp_out toggles once per word.
REQ-036 Any run -> an assertion confirms set_o and clkp_o never toggle in the same cycle, and every set-to-clkp gap is at least SETUP_CYC cycles.
